// File: rtl/isa_secuenciador.sv
// isa_secuenciador: buffers 20-bit instructions in a FIFO and issues each one over three cycles with single-cycle write enables
module isa_secuenciador #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [19:0]      in_data,
   output logic             in_ready,
   input  logic             pausa,
   output logic [19:0]      Instruccion,
   output logic             ocupado,
   output logic [CNT_W-1:0] retirados,
   output logic [AW:0]      nivel
);
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;
   state_t           state_q, state_d;
   logic [19:0]      mem_q [DEPTH];
   logic [19:0]      mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [19:0]      ir_q, ir_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             push, disp;
   // FIFO bookkeeping, dispatch decision, FSM next state and datapath drive
   always_comb begin
      in_ready = cnt_q != (AW+1)'(DEPTH);
      push     = in_valid && in_ready;
      disp     = (cnt_q != '0) && !pausa && (state_q == IDLE || state_q == WRITE);
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = in_data;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = disp ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(disp);
      ir_d     = disp ? mem_q[rd_ptr_q] : ir_q;
      ret_d    = state_q == WRITE ? ret_q + CNT_W'(1) : ret_q;
      state_d  = state_q;
      unique case (state_q)
         IDLE:    state_d = disp ? DECODE : IDLE;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = WRITE;
         default: state_d = disp ? DECODE : IDLE;
      endcase
      Instruccion = state_q == IDLE  ? 20'h0 :
                    state_q == WRITE ? ir_q  : {ir_q[19:10], 1'b0, ir_q[8:1], 1'b0};
      ocupado   = state_q != IDLE;
      retirados = ret_q;
      nivel     = cnt_q;
   end
   // state registers; reset abandons the in-flight instruction and empties the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ir_q     <= '0;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ir_q     <= ir_d;
         ret_q    <= ret_d;
      end
   end
endmodule

// File: tb/tb_isa_secuenciador.sv
// tb_isa_secuenciador: directed checks of dispatch timing, FIFO flow control, pause, reset and counter wrap
module tb_isa_secuenciador;
   logic        clk = 0, rst = 1, in_valid = 0, pausa = 0;
   logic [19:0] in_data = '0;
   logic        in_ready, ocupado, in_ready3, ocupado3;
   logic [19:0] instr, instr3;
   logic [15:0] ret;
   logic [2:0]  ret3, nivel, nivel3;
   int checks = 0, failures = 0;
   logic [19:0] w [4];
   logic [19:0] f [6];

   isa_secuenciador dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .pausa(pausa), .Instruccion(instr), .ocupado(ocupado),
      .retirados(ret), .nivel(nivel));
   isa_secuenciador #(.CNT_W(3)) dut3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready3), .pausa(pausa), .Instruccion(instr3), .ocupado(ocupado3),
      .retirados(ret3), .nivel(nivel3));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1; in_valid = 0; pausa = 0;
      tick; tick;
      rst = 0;
   endtask

   function automatic logic [19:0] mask(input logic [19:0] x);
      return x & ~20'h00201;
   endfunction

   initial begin
      w = '{20'h11201, 20'h22203, 20'h33205, 20'h44207};
      f = '{20'h10201, 20'h20203, 20'h30205, 20'h40207, 20'h50209, 20'h6020B};
      // reset state
      do_reset;
      chk("rst_nivel", nivel, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_instr", instr, 0);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_ret", ret, 0);
      // single instruction
      in_valid = 1; in_data = 20'h84A3B;
      tick; in_valid = 0;
      chk("s_idle_instr", instr, 0);
      chk("s_nivel1", nivel, 1);
      tick;
      chk("s_decode", instr, 20'h8483A);
      chk("s_dec_ocup", ocupado, 1);
      chk("s_dec_nivel", nivel, 0);
      tick;
      chk("s_exec", instr, 20'h8483A);
      tick;
      chk("s_write", instr, 20'h84A3B);
      chk("s_write_ret", ret, 0);
      tick;
      chk("s_ret", ret, 1);
      chk("s_ocup_fall", ocupado, 0);
      chk("s_instr0", instr, 0);
      // back-to-back
      do_reset;
      in_valid = 1; in_data = w[0]; tick;
      chk("b_nivel_p0", nivel, 1);
      in_data = w[1]; tick;
      chk("b_nivel_p1", nivel, 1);
      in_data = w[2]; tick;
      chk("b_nivel_p2", nivel, 2);
      in_data = w[3]; tick;
      chk("b_nivel_p3", nivel, 3);
      chk("b_write0", instr, w[0]);
      in_valid = 0;
      for (int k = 4; k <= 12; k++) begin
         tick;
         chk("b_busy", ocupado, 1);
         chk("b_we_pulse", {instr[9], instr[0]}, (k % 3 == 0) ? 2'b11 : 2'b00);
         if (k % 3 == 0) chk("b_write_word", instr, w[k/3 - 1]);
      end
      chk("b_ret3", ret, 3);
      tick;
      chk("b_ret4", ret, 4);
      chk("b_idle", ocupado, 0);
      // full FIFO under pause
      do_reset;
      pausa = 1; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         in_data = f[i];
         tick;
      end
      chk("f_nivel4", nivel, 4);
      chk("f_ready0", in_ready, 0);
      in_data = f[4];
      tick;
      chk("f_hold_nivel", nivel, 4);
      chk("f_hold_idle", ocupado, 0);
      pausa = 0;
      tick;
      chk("f_r0_nivel", nivel, 3);
      chk("f_r0_ready", in_ready, 1);
      chk("f_r0_decode", instr, mask(f[0]));
      tick;
      chk("f_r1_nivel", nivel, 4);
      in_data = f[5];
      tick;
      chk("f_r2_write", instr, f[0]);
      chk("f_r2_ready", in_ready, 0);
      tick;
      chk("f_r3_nivel", nivel, 3);
      tick;
      chk("f_r4_nivel", nivel, 4);
      in_valid = 0;
      tick;
      chk("f_write1", instr, f[1]);
      for (int i = 2; i < 6; i++) begin
         tick; tick; tick;
         chk("f_write_order", instr, f[i]);
      end
      tick;
      chk("f_ret6", ret, 6);
      chk("f_nivel0", nivel, 0);
      // pause during execution
      do_reset;
      in_valid = 1; in_data = w[0]; tick;
      in_data = w[1]; tick;
      in_valid = 0; tick;
      pausa = 1;
      tick;
      chk("p_write_a", instr, w[0]);
      tick;
      chk("p_idle", ocupado, 0);
      chk("p_ret", ret, 1);
      chk("p_nivel", nivel, 1);
      tick;
      chk("p_still_idle", ocupado, 0);
      pausa = 0;
      tick;
      chk("p_dispatch_b", instr, mask(w[1]));
      chk("p_nivel0", nivel, 0);
      // reset mid-operation
      do_reset;
      in_valid = 1; in_data = w[2]; tick;
      in_data = w[3]; tick;
      in_valid = 0; tick;
      chk("r_exec", instr, mask(w[2]));
      rst = 1;
      tick;
      rst = 0;
      chk("r_nivel", nivel, 0);
      chk("r_ret", ret, 0);
      for (int k = 0; k < 5; k++) begin
         chk("r_no_we", {instr[9], instr[0]}, 2'b00);
         chk("r_ocup", ocupado, 0);
         tick;
      end
      chk("r_ret_after", ret, 0);
      // counter wrap on the narrow-counter instance
      do_reset;
      begin
         int sent = 0, cyc = 0;
         logic acc;
         while ((sent < 9 || ocupado || nivel != 0) && cyc < 200) begin
            in_valid = sent < 9;
            in_data = 20'h00201 | 20'(sent << 12);
            acc = in_valid && in_ready;
            tick;
            if (acc) sent++;
            cyc++;
         end
         in_valid = 0;
         chk("w_done_in_budget", cyc < 200, 1);
      end
      chk("w_ret3_wrap", ret3, 1);
      chk("w_ret16", ret, 9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/isa_secuenciador.md
# isa_secuenciador

Instruction sequencer for the 20-bit ISA datapath (register file → ALU → RAM). It accepts instructions from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Each instruction is presented to the datapath's `Instruccion` input for three cycles, and the register-file and RAM write enables are gated to a single-cycle pulse in the last cycle. The block sits between the instruction source and the datapath and is the only driver of `Instruccion`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  producer has an instruction on `in_data`.
- `in_data`  in  20  instruction: [19:15] DL1, [14:10] DL2, [9] RF WE, [8:6] AluOp, [5:1] DirRam, [0] RAM WE.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `pausa`  in  1  when high, blocks dispatch of new instructions; an instruction already in flight completes.
- `Instruccion`  out  20  drive to the datapath.
- `ocupado`  out  1  high in any state other than IDLE.
- `retirados`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.
- `nivel`  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- FIFO:
  - A push occurs when `in_valid && in_ready`.
  - A pop occurs when the FSM dispatches.
  - A push and a pop in the same cycle are both performed; when full, `in_ready`=0, so there is no push.
  - Occupancy changes by +1, −1 or 0; pointers wrap modulo DEPTH.
- Current-instruction register `ir` (20 b) loads the FIFO head on dispatch.
- Dispatch condition: `nivel != 0 && !pausa`, evaluated in IDLE and in WRITE.
- FSM states and transitions:
  - IDLE: dispatch condition true → load `ir`, pop, go to DECODE; otherwise stay.
  - DECODE → EXEC (unconditional).
  - EXEC → WRITE (unconditional).
  - WRITE: `retirados`++; if dispatch condition true → load `ir`, pop, go to DECODE; otherwise go to IDLE.
- `Instruccion` drive per state:
  - IDLE: all zeros.
  - DECODE and EXEC: `{ir[19:10], 1'b0, ir[8:1], 1'b0}`. Both write enables are forced to 0 so operands and ALU result settle.
  - WRITE: `ir` unmodified, so `ir[9]` and `ir[0]` appear for exactly one cycle.
- `pausa` does not alter DECODE, EXEC or WRITE sequencing; it only suppresses dispatch.
- Reset values:
  - State = IDLE.
  - FIFO empty: `nivel`=0, `in_ready`=1.
  - `ir`=0, `Instruccion`=0, `ocupado`=0, `retirados`=0.
- Reset mid-operation: the in-flight instruction is abandoned and the FIFO contents are discarded. No write-enable pulse is emitted after the reset edge, and `retirados` does not count the abandoned instruction.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `in_valid` or `pausa` to `Instruccion`.
- `in_ready` depends only on FIFO occupancy.
- Latency, empty FIFO and FSM in IDLE, with a push at edge E0:
  - E1: dispatch; DECODE in the cycle after E1.
  - E2: EXEC.
  - E3: WRITE; the enable pulse is visible between E3 and E4.
  - E4: `retirados` increments.
- Throughput: back-to-back instructions take 3 cycles each with no IDLE gap while the FIFO is non-empty.
- Counter wrap: `retirados` goes from 2^CNT_W−1 to 0.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 that cycle and rises in the next.

## Test plan
- Single instruction: push 0x8_4A_3B after reset.
  - `Instruccion`=0 until dispatch.
  - DECODE and EXEC cycles show 0x84A3B with bits 9 and 0 cleared.
  - The WRITE cycle shows 0x84A3B.
  - `retirados`=1 afterward and `ocupado` falls.
- Back-to-back: push 4 instructions in consecutive cycles.
  - `nivel` peaks at 3 (one already dispatched).
  - The write pulses are exactly 3 cycles apart.
  - `retirados`=4 twelve cycles after the first dispatch, with no IDLE cycle in between.
- Full FIFO: hold `in_valid`=1 with 6 distinct words while `pausa`=1.
  - `in_ready` drops after 4 accepted words.
  - Releasing `pausa` drains the FIFO in push order, and the 5th word is accepted only after the first pop.
- Pause during execution: assert `pausa` during EXEC of instruction A while B is queued.
  - A's WRITE still occurs.
  - The FSM goes to IDLE and B is dispatched on the first edge after `pausa` falls.
- Reset mid-op: assert `rst` in the EXEC cycle of an instruction with bits 9 and 0 set.
  - No cycle after the reset edge has bit 9 or bit 0 set.
  - `nivel`=0 and `retirados`=0.
- Counter wrap, run with CNT_W=3: retire 9 instructions → `retirados`=1.
